// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM
// and registers the returned word with its PC into the IF/ID register.
module fetch_stage #(
    parameter int                 POS      = 1024,
    parameter int                 NUM_BITS = 32,
    parameter logic [NUM_BITS-1:0] RESET_PC = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [NUM_BITS-1:0]      redirect_pc,
    output logic [$clog2(POS)-1:0]   rom_addr,
    input  logic [NUM_BITS-1:0]      rom_dout,
    output logic                     if_valid,
    output logic [NUM_BITS-1:0]      if_pc,
    output logic [NUM_BITS-1:0]      if_instr,
    output logic [31:0]              fetch_count,
    output logic                     fetch_err
);

    localparam int AW = $clog2(POS);
    localparam logic [NUM_BITS:0] LIMIT = (NUM_BITS+1)'(POS) << 2;
    localparam logic [NUM_BITS-1:0] NOP = NUM_BITS'(32'h0000_0013);

    logic [NUM_BITS-1:0] pc;
    logic                advance;
    logic                out_of_range;
    logic                misaligned;

    // ROM sees only the word-index bits of the PC
    assign rom_addr     = pc[AW+1:2];
    assign advance      = !redirect_valid && !stall;
    assign out_of_range = {1'b0, pc} >= LIMIT;
    assign misaligned   = redirect_pc[1:0] != 2'b00;

    // PC update: redirect beats stall, stall beats sequential advance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[NUM_BITS-1:2], 2'b00};
        end else if (!stall) begin
            pc <= pc + NUM_BITS'(4);
        end
    end

    // IF/ID register: capture on advance, flush to a NOP bubble on redirect
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP;
        end else if (redirect_valid) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP;
        end else if (!stall) begin
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= rom_dout;
        end
    end

    // Delivered-instruction counter; discarded words are not counted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_count <= '0;
        end else if (advance) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // Sticky error: misaligned redirect target or fetch beyond ROM
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_err <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            fetch_err <= 1'b1;
        end else if (advance && out_of_range) begin
            fetch_err <= 1'b1;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue core. Holds the program counter, drives the word address of the combinational instruction ROM, and registers the returned word into the IF/ID pipeline register together with its PC. Sits directly upstream of the ROM address input and directly downstream of its data output. Accepts stall and redirect (branch/jump) requests from later stages.

## Interface
- POS, 1024, ROM depth in 32-bit words; ROM address width is $clog2(POS)
- NUM_BITS, 32, instruction and PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- stall  input  1  hold PC and IF/ID register this cycle
- redirect_valid  input  1  load redirect_pc into PC and flush IF/ID
- redirect_pc  input  NUM_BITS  byte address of next instruction on redirect
- rom_addr  output  $clog2(POS)  word address to ROM, equals pc[$clog2(POS)+1:2]
- rom_dout  input  NUM_BITS  instruction word returned combinationally by ROM
- if_valid  output  1  IF/ID register holds a real instruction
- if_pc  output  NUM_BITS  byte PC of if_instr
- if_instr  output  NUM_BITS  registered instruction
- fetch_count  output  32  number of instructions delivered since reset
- fetch_err  output  1  sticky error flag

## Operation
- Internal state: pc register, IF/ID register (if_valid, if_pc, if_instr), fetch_count, fetch_err.
- rom_addr is purely combinational from pc; pc[1:0] never reaches the ROM.
- Per-cycle priority: RST > redirect_valid > stall > normal advance.
- Normal advance (no stall, no redirect): if_instr <= rom_dout, if_pc <= pc, if_valid <= 1, pc <= pc + 4, fetch_count <= fetch_count + 1.
- Stall (no redirect): pc, IF/ID, fetch_count all hold their values.
- Redirect (stall ignored): pc <= {redirect_pc[NUM_BITS-1:2], 2'b00}; if_valid <= 0, if_instr <= 32'h0000_0013 (NOP), if_pc <= 0; word fetched in this cycle is discarded and not counted.
- Redirect with redirect_pc[1:0] != 0: low bits forced to zero as above, and fetch_err <= 1.
- Advance with pc >= POS*4: rom_addr wraps (index bits only), fetch proceeds normally, and fetch_err <= 1.
- fetch_err is sticky; only RST clears it.
- pc arithmetic is modulo 2^NUM_BITS; pc + 4 at 32'hFFFF_FFFC wraps to 0 (also sets fetch_err via range rule).
- fetch_count wraps modulo 2^32 without error.

## Timing
- Reset values: pc = RESET_PC, rom_addr = RESET_PC index bits, if_valid = 0, if_pc = 0, if_instr = 32'h0000_0013, fetch_count = 0, fetch_err = 0.
- Reset is asynchronous on assertion: all outputs take reset values immediately, mid-operation included; in-flight IF/ID content is lost.
- Latency: instruction at PC p appears on if_instr/if_pc one rising edge after pc == p with no stall.
- First edge after RST deasserts: IF/ID captures ROM word 0, if_valid = 1, pc = 4.
- Redirect asserted at edge k: if_valid = 0 after edge k; instruction at redirect target valid after edge k+1 (one bubble).
- Stall held for N cycles: outputs frozen for N edges; no duplicate or dropped instruction.
- Simultaneous stall and redirect: redirect behaviour exactly.

## Test plan
- Reset release with ROM loaded from fibonacci.txt, no stall -> if_instr sequence 32'h10000197, 32'h0001a383, 32'h00818413, 32'h00418493 on successive edges; if_pc 0, 4, 8, 12; fetch_count 1..4; rom_addr 0,1,2,3,4.
- Stall high for 3 cycles while if_pc = 4 -> if_instr stays 32'h0001a383, pc stays 8, fetch_count stays 2; after release next if_instr = 32'h00818413.
- redirect_valid with redirect_pc = 32'h0000_0004 and stall both high at pc = 12 -> next edge if_valid = 0, if_instr = 32'h00000013; following edge if_instr = 32'h0001a383, if_pc = 4; fetch_err = 0.
- redirect_pc = 32'h0000_0006 -> pc = 4, fetch_err = 1 and remains 1 through later normal fetches until RST.
- Run pc up to 4092 (POS = 1024) -> fetch at 4092 reads word 1023, fetch_err = 0; next fetch at pc 4096 drives rom_addr = 0, fetch_err = 1.
- Assert RST asynchronously mid-cycle with if_valid = 1 -> outputs at reset values before next CLK edge; fetch_count = 0.
